pc_trap_sel: RTL and testbench

- Parametrised next-generation program-counter selector for the RISC-V core.
- Owns the architectural PC register and arbitrates between sequential/branch flow, a multi-source interrupt trap, and trap return.
- Supports direct and vectored trap-vector modes, sticky interrupt pending bits, stall handling and a two-state handler tracking FSM.
- Sits between the fetch stage and the CSR file. It consumes the next-PC value from the branch/increment logic, plus mtvec, mepc and the mret decode.

---
 rtl/pc_trap_sel_pkg.sv | 23 ++
 rtl/pc_trap_sel_irq_prio_enc.sv | 29 ++
 rtl/pc_trap_sel.sv | 129 ++++++++++++
 tb/tb_pc_trap_sel.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pc_trap_sel_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pc_trap_sel_pkg
//  Brief    : Shared constants for the PC/trap selector and its encoder.
//  Revision : 1.0 - initial release
// ============================================================================
package pc_trap_sel_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_HANDLER = 1'b1;

  localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

  // Cause index width; never narrower than one bit.
  function automatic int cause_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : pc_trap_sel_pkg
`default_nettype wire

// File: rtl/pc_trap_sel_irq_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module   : irq_prio_enc
//  Brief    : Combinational lowest-index-first priority encoder with valid.
//  Revision : 1.0 - initial release
// ============================================================================
module irq_prio_enc
  import pc_trap_sel_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0]          req,
  output logic [cause_w(NUM_IRQ)-1:0] idx,
  output logic                        valid
);

  localparam int CW = cause_w(NUM_IRQ);

  // Scan high to low so the lowest set index is written last and wins.
  always_comb begin
    idx   = '0;
    valid = |req;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) idx = CW'(i);
    end
  end

endmodule : irq_prio_enc
`default_nettype wire

// File: rtl/pc_trap_sel.sv
`default_nettype none
// ============================================================================
//  Module   : pc_trap_sel
//  Brief    : Architectural PC register with interrupt trap entry and mret.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_trap_sel
  import pc_trap_sel_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              NUM_IRQ  = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                        I_clk,
  input  logic                        I_rst_n,
  input  logic                        I_stall,
  input  logic [NUM_IRQ-1:0]          I_irq,
  input  logic [NUM_IRQ-1:0]          I_irq_mask,
  input  logic                        I_irq_en,
  input  logic [XLEN-1:0]             I_mtvec,
  input  logic [XLEN-1:0]             I_mepc,
  input  logic                        I_mret,
  input  logic [XLEN-1:0]             I_data,
  output logic [XLEN-1:0]             O_data,
  output logic                        O_trap_taken,
  output logic [cause_w(NUM_IRQ)-1:0] O_cause,
  output logic [XLEN-1:0]             O_epc,
  output logic                        O_in_handler
);

  localparam int CW = cause_w(NUM_IRQ);

  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;
  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] w_pend_cap;
  logic [NUM_IRQ-1:0] w_elig;
  logic [NUM_IRQ-1:0] w_clr;
  logic [CW-1:0]      w_sel;
  logic               w_sel_vld;
  logic               w_take;
  logic [XLEN-1:0]    w_base;
  logic [XLEN-1:0]    w_target;
  logic [XLEN-1:0]    w_pc_nxt;
  logic [XLEN-1:0]    r_pc;
  logic [XLEN-1:0]    r_epc;
  logic [CW-1:0]      r_cause;
  logic               r_trap_taken;

  // A request captured on this edge is already visible to arbitration,
  // so a one-cycle pulse is taken on the very next edge.
  assign w_pend_cap = r_pending | I_irq;
  assign w_elig     = w_pend_cap & I_irq_mask & {NUM_IRQ{I_irq_en}};

  irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ)
  ) u_prio (
    .req   (w_elig),
    .idx   (w_sel),
    .valid (w_sel_vld)
  );

  assign w_take = !I_stall && (r_state == ST_RUN) && w_sel_vld;
  assign w_clr  = w_take ? (NUM_IRQ'(1) << w_sel) : '0;

  assign w_base   = {I_mtvec[XLEN-1:2], 2'b00};
  assign w_target = (I_mtvec[1:0] == MTVEC_VECTORED)
                  ? w_base + {{(XLEN-CW-2){1'b0}}, w_sel, 2'b00}
                  : w_base;

  // State register
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) r_state <= ST_RUN;
    else          r_state <= w_state_nxt;
  end

  // Next-state and next-PC selection
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    if (!I_stall) begin
      w_pc_nxt = I_data;
      case (r_state)
        ST_RUN: begin
          if (w_sel_vld) begin
            w_pc_nxt    = w_target;
            w_state_nxt = ST_HANDLER;
          end
        end
        default: begin
          if (I_mret) begin
            w_pc_nxt    = I_mepc;
            w_state_nxt = ST_RUN;
          end
        end
      endcase
    end
  end

  // State-derived outputs
  always_comb begin
    O_in_handler = (r_state == ST_HANDLER);
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_pc         <= RESET_PC;
      r_pending    <= '0;
      r_epc        <= '0;
      r_cause      <= '0;
      r_trap_taken <= 1'b0;
    end else begin
      r_pc         <= w_pc_nxt;
      r_pending    <= w_pend_cap & ~w_clr;
      r_trap_taken <= w_take;
      if (w_take) begin
        r_epc   <= I_data;
        r_cause <= w_sel;
      end
    end
  end

  assign O_data       = r_pc;
  assign O_epc        = r_epc;
  assign O_cause      = r_cause;
  assign O_trap_taken = r_trap_taken;

endmodule : pc_trap_sel
`default_nettype wire

// File: tb/tb_pc_trap_sel.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_trap_sel
//  Brief    : Directed self-checking bench for pc_trap_sel.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_trap_sel;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [3:0]  irq;
  logic [3:0]  irq_mask;
  logic        irq_en;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        mret;
  logic [31:0] data_in;
  logic [31:0] pc;
  logic        trap_taken;
  logic [1:0]  cause;
  logic [31:0] epc;
  logic        in_handler;

  int n_checks = 0;
  int n_errors = 0;

  pc_trap_sel #(
    .XLEN     (32),
    .NUM_IRQ  (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .I_clk        (clk),
    .I_rst_n      (rst_n),
    .I_stall      (stall),
    .I_irq        (irq),
    .I_irq_mask   (irq_mask),
    .I_irq_en     (irq_en),
    .I_mtvec      (mtvec),
    .I_mepc       (mepc),
    .I_mret       (mret),
    .I_data       (data_in),
    .O_data       (pc),
    .O_trap_taken (trap_taken),
    .O_cause      (cause),
    .O_epc        (epc),
    .O_in_handler (in_handler)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; irq = 4'h0; irq_mask = 4'hF; irq_en = 1'b1;
    mtvec = 32'h100; mepc = 32'h0; mret = 1'b0; data_in = 32'h0;
    #12;
    chk("rst_pc",    pc, 32'h0);
    chk("rst_trap",  {31'b0, trap_taken}, 32'h0);
    chk("rst_cause", {30'b0, cause}, 32'h0);
    chk("rst_epc",   epc, 32'h0);
    chk("rst_inh",   {31'b0, in_handler}, 32'h0);
    rst_n = 1'b1;

    // Sequential flow, one cycle late
    for (int k = 1; k <= 3; k++) begin
      data_in = 32'(4 * k);
      step();
      chk("seq_pc",   pc, 32'(4 * k));
      chk("seq_trap", {31'b0, trap_taken}, 32'h0);
    end

    // Direct trap on IRQ2
    data_in = 32'h10; irq = 4'b0100;
    step();
    chk("dir_pc",    pc, 32'h100);
    chk("dir_cause", {30'b0, cause}, 32'h2);
    chk("dir_epc",   epc, 32'h10);
    chk("dir_trap",  {31'b0, trap_taken}, 32'h1);
    chk("dir_inh",   {31'b0, in_handler}, 32'h1);
    irq = 4'h0; data_in = 32'h104;
    step();
    chk("dir_pulse", {31'b0, trap_taken}, 32'h0);
    chk("dir_flow",  pc, 32'h104);
    mret = 1'b1; mepc = 32'h14;
    step();
    chk("dir_mret", pc, 32'h14);
    chk("dir_run",  {31'b0, in_handler}, 32'h0);
    mret = 1'b0;

    // Vectored priority and tail-chain
    mtvec = 32'h201; data_in = 32'h18; irq = 4'b1010;
    step();
    chk("vec_pc",    pc, 32'h204);
    chk("vec_cause", {30'b0, cause}, 32'h1);
    chk("vec_epc",   epc, 32'h18);
    irq = 4'h0; mret = 1'b1; mepc = 32'h40; data_in = 32'h208;
    step();
    chk("tc_mret", pc, 32'h40);
    chk("tc_inh",  {31'b0, in_handler}, 32'h0);
    mret = 1'b0; data_in = 32'h44;
    step();
    chk("tc_pc",    pc, 32'h20C);
    chk("tc_cause", {30'b0, cause}, 32'h3);
    chk("tc_epc",   epc, 32'h44);
    chk("tc_trap",  {31'b0, trap_taken}, 32'h1);
    mret = 1'b1; mepc = 32'h48;
    step();
    chk("tc_ret", pc, 32'h48);
    mret = 1'b0;

    // Masking, then late enable from retained pending bit
    irq_mask = 4'h0; irq = 4'hF; data_in = 32'h50;
    step();
    chk("mask_pc",   pc, 32'h50);
    chk("mask_trap", {31'b0, trap_taken}, 32'h0);
    irq = 4'h0; irq_en = 1'b0; irq_mask = 4'hF; data_in = 32'h54;
    step();
    chk("gen_pc",   pc, 32'h54);
    chk("gen_trap", {31'b0, trap_taken}, 32'h0);
    irq_en = 1'b1; irq_mask = 4'b1000; data_in = 32'h58;
    step();
    chk("late_trap",  {31'b0, trap_taken}, 32'h1);
    chk("late_cause", {30'b0, cause}, 32'h3);
    chk("late_pc",    pc, 32'h20C);

    // Asynchronous reset while in HANDLER
    rst_n = 1'b0;
    #1;
    chk("arst_pc",  pc, 32'h0);
    chk("arst_inh", {31'b0, in_handler}, 32'h0);
    #2;
    rst_n = 1'b1; irq_mask = 4'hF; data_in = 32'h60;
    step();
    chk("arst_pend", {31'b0, trap_taken}, 32'h0);
    chk("arst_flow", pc, 32'h60);

    // IRQ0 during a three-cycle stall
    stall = 1'b1; irq = 4'b0001; data_in = 32'h70;
    for (int k = 0; k < 3; k++) begin
      step();
      irq = 4'h0;
      chk("stl_pc",   pc, 32'h60);
      chk("stl_trap", {31'b0, trap_taken}, 32'h0);
    end
    stall = 1'b0; data_in = 32'h74;
    step();
    chk("stl_take",  {31'b0, trap_taken}, 32'h1);
    chk("stl_cause", {30'b0, cause}, 32'h0);
    chk("stl_tpc",   pc, 32'h200);
    chk("stl_epc",   epc, 32'h74);

    // Stalled mret is held off
    stall = 1'b1; mret = 1'b1; mepc = 32'h80;
    step();
    chk("smret_pc",  pc, 32'h200);
    chk("smret_inh", {31'b0, in_handler}, 32'h1);
    stall = 1'b0;
    step();
    chk("smret_ret", pc, 32'h80);
    mret = 1'b0;

    // Mode 2'b10 behaves as direct
    mtvec = 32'h302; irq = 4'b0100; data_in = 32'h90;
    step();
    chk("m10_pc",    pc, 32'h300);
    chk("m10_cause", {30'b0, cause}, 32'h2);
    irq = 4'h0; mret = 1'b1; mepc = 32'h94;
    step();
    mret = 1'b0;

    // Vectored target wraps modulo 2^32
    mtvec = 32'hFFFF_FFFD; irq = 4'b0100; data_in = 32'h98;
    step();
    chk("wrap_pc", pc, 32'h0000_0004);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_pc_trap_sel
`default_nettype wire
